ad_rd_sched: RTL and testbench
==============================

# ad_rd_sched

Read-side scheduler for the ping-pong AD cache, running in the USB clock domain. It detects each half-buffer swap on the cache `switch` output and bursts one frame to the USB slave FIFO. A frame is a two-word header followed by `FRAME_WORDS` cache words. The scheduler paces the cache `rd` strobe against USB back-pressure through a 4-entry skid buffer. It flags overruns when the writer swaps halves before the frame finishes.

## Interface
Parameters:
- `FRAME_WORDS`, default 3072: USB words read from one cache half per frame; must be a multiple of 3.
- `RD_LAT`, default 2: cycles from a `cache_rd` high cycle to its `cache_rdata` word being valid.
- `HDR_WORD`, default 16'hEB90: first header word.
- `USB_DATA_NBIT`, default 16: USB word width.

Ports:
- `clk` in 1: USB/read clock; same clock as the cache `rclk`.
- `rst_n` in 1: reset; asynchronous, active-low.
- `en` in 1: host enable, level.
- `switch` in 1: cache half-select, already synchronised to `clk`.
- `cache_rd` out 1: cache read strobe, one USB word per high cycle.
- `cache_rdata` in `USB_DATA_NBIT`: cache read data.
- `usb_full` in 1: USB FIFO full, active-high.
- `usb_wr` out 1: USB FIFO write strobe; a word is accepted when `usb_wr` is high and `usb_full` is low.
- `usb_data` out `USB_DATA_NBIT`: USB write data.
- `usb_pktend` out 1: one-cycle pulse after the last word of a frame.
- `overrun` out 1: sticky; cleared only when `en` falls.
- `frame_cnt` out 16: count of completed frames; wraps.

## Operation
- Toggle detect: `sw_d` registers `switch`. `swap = switch ^ sw_d`.
- States: IDLE, HDR0, HDR1, BURST, DRAIN, END.
- IDLE:
  - Moves to HDR0 on `swap` when `en`=1.
  - While `en`=0: `overrun` is cleared, the skid buffer is flushed, and `swap` is ignored.
- HDR0 pushes `HDR_WORD` into the skid buffer. HDR1 pushes `frame_cnt`. Each push happens only when the buffer is not full; otherwise the state holds.
- BURST:
  - Raises `cache_rd` when `occ + inflight <= 3`, where `occ` is skid-buffer occupancy and `inflight` is the number of `cache_rd` cycles within the last `RD_LAT` cycles.
  - Each word arriving `RD_LAT` cycles after its `cache_rd` cycle is pushed into the skid buffer.
  - Words issued are counted. After `FRAME_WORDS` issues, the state goes to DRAIN.
  - `cache_rd` must never be high outside BURST. Gaps in `cache_rd` are allowed: the cache read pointer advances only on `rd` cycles.
- DRAIN waits until `inflight`=0 and the skid buffer is empty, then goes to END.
- END:
  - Pulses `usb_pktend` for one cycle.
  - Increments `frame_cnt`.
  - Returns to IDLE.
- Skid buffer:
  - 4 × `USB_DATA_NBIT`.
  - Pops when `usb_wr` is high and `usb_full` is low.
  - `usb_wr` = not empty. `usb_data` = head entry.
  - A simultaneous push and pop leaves occupancy unchanged.
  - The credit rule guarantees it never overflows. The bench asserts this.
- Overrun: `swap` seen in HDR0, HDR1, BURST or DRAIN means:
  - set `overrun`;
  - stop issuing `cache_rd`;
  - let in-flight words land and drain them;
  - emit `usb_pktend`; do not increment `frame_cnt`;
  - go directly to HDR0 for the new half.
  The cache resets its read pointer on the swap, so the new frame starts at address 0.
- `en` falling mid-frame: finish the current state sequence normally. `en` is re-sampled only in IDLE.

## Timing
- Reset values:
  - `cache_rd`=0, `usb_wr`=0, `usb_pktend`=0, `overrun`=0, `frame_cnt`=0.
  - State=IDLE.
  - Skid buffer empty; `usb_data`=0.
  - `sw_d` is loaded with 0, so a `switch` already high after reset produces one `swap`.
- Latency:
  - `swap` cycle n → HDR0 at n+1.
  - `usb_wr` high with `HDR_WORD` at n+2.
  - First `cache_rd` at n+3 if `usb_full`=0.
- Steady state, `usb_full`=0:
  - One USB word per cycle.
  - Frame length `FRAME_WORDS`+2 words.
  - `usb_pktend` 1 cycle after the last pop (state END).
- `usb_full` asserted:
  - At most 4 − `occ` further `cache_rd` cycles.
  - `usb_wr` stays high with the same `usb_data` until accepted.
- `swap` coincident with END: the frame completes normally, then go to HDR0 next cycle. No overrun.

## Test plan
- Reset and idle: reset, `en`=1, no toggles → all outputs 0 for 100 cycles.
- Clean frame: `FRAME_WORDS`=12, cache model returns addr-indexed data, `swap` once, `usb_full`=0:
  - 14 words: EB90, 0000, D0..D11.
  - Then one `usb_pktend`; `frame_cnt`=1.
- Back-pressure: same frame with `usb_full` toggled pseudo-randomly at 50%:
  - identical word sequence;
  - skid occupancy never exceeds 4;
  - no word is dropped or duplicated.
- Overrun: second `swap` after 5 BURST reads:
  - partial frame of 2 + 5 words, then `usb_pktend`;
  - `overrun`=1, `frame_cnt` unchanged;
  - new frame starts with header word 1 = old `frame_cnt`, data from addr 0.
- Enable gating:
  - `en`=0 with toggles → no traffic.
  - `en` 1→0 during BURST → the current frame completes, then no further frames; `overrun` cleared.
- Async reset mid-BURST: assert `rst_n`=0 → all outputs 0 immediately. After release, the next `swap` yields `frame_cnt` header 0000.

Source files
------------

// File: rtl/ad_rd_sched.sv
// ad_rd_sched: read-side scheduler for the ping-pong AD cache (USB clock domain).
// On each half-buffer swap it emits a two-word header followed by FRAME_WORDS
// cache words into the USB slave FIFO. Cache reads are paced by a credit rule
// against a 4-entry skid buffer. A swap that arrives mid-frame aborts the frame
// and raises a sticky overrun flag.
module ad_rd_sched #(
    parameter int          FRAME_WORDS   = 3072,
    parameter int          RD_LAT        = 2,
    parameter logic [15:0] HDR_WORD      = 16'hEB90,
    parameter int          USB_DATA_NBIT = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     switch,
    output logic                     cache_rd,
    input  logic [USB_DATA_NBIT-1:0] cache_rdata,
    input  logic                     usb_full,
    output logic                     usb_wr,
    output logic [USB_DATA_NBIT-1:0] usb_data,
    output logic                     usb_pktend,
    output logic                     overrun,
    output logic [15:0]              frame_cnt
);

    localparam int CNT_W = $clog2(FRAME_WORDS + 1);
    localparam int LAT_W = $clog2(RD_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR0  = 3'd1,
        S_HDR1  = 3'd2,
        S_BURST = 3'd3,
        S_DRAIN = 3'd4,
        S_END   = 3'd5
    } state_t;

    state_t                   state_q, state_d;
    logic                     sw_q;
    logic                     swap;
    logic                     frame_swap;
    logic                     abort_q, abort_d;
    logic                     ovr_q, ovr_d;
    logic [15:0]              fcnt_q, fcnt_d;
    logic [CNT_W-1:0]         issue_q, issue_d;
    logic [RD_LAT-1:0]        rd_pipe_q;
    logic [LAT_W-1:0]         inflight;
    logic                     land;
    logic                     credit_ok;
    logic [USB_DATA_NBIT-1:0] skid_q [4];
    logic [1:0]               wptr_q, wptr_d;
    logic [1:0]               rptr_q, rptr_d;
    logic [2:0]               occ_q, occ_d;
    logic                     flush;
    logic                     pop;
    logic                     push;
    logic                     hdr_push;
    logic [USB_DATA_NBIT-1:0] hdr_data;
    logic [USB_DATA_NBIT-1:0] push_data;

    // A swap is any change of the half-select since the previous cycle.
    assign swap = switch ^ sw_q;

    // A swap while a frame is in progress (not IDLE, not END) is an overrun.
    assign frame_swap = swap && ((state_q == S_HDR0) || (state_q == S_HDR1) ||
                                 (state_q == S_BURST) || (state_q == S_DRAIN));

    // The oldest bit of the read pipeline marks the cycle its data is valid.
    assign land = rd_pipe_q[RD_LAT-1];

    // Count cache reads issued within the last RD_LAT cycles (words still owed).
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + LAT_W'(rd_pipe_q[i]);
        end
    end

    // Only issue a read if the buffer can absorb every word already owed plus this one.
    assign credit_ok = (int'(occ_q) + int'(inflight)) <= 3;

    assign usb_wr    = (occ_q != 3'd0);
    assign usb_data  = skid_q[rptr_q];
    assign pop       = usb_wr && !usb_full;
    assign flush     = (state_q == S_IDLE) && !en;
    assign push      = hdr_push || land;
    assign push_data = land ? cache_rdata : hdr_data;
    assign overrun   = ovr_q;
    assign frame_cnt = fcnt_q;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: any mid-frame swap diverts to DRAIN so owed words still land.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (en && swap) state_d = S_HDR0;
            end
            S_HDR0: begin
                if (swap)          state_d = S_DRAIN;
                else if (hdr_push) state_d = S_HDR1;
            end
            S_HDR1: begin
                if (swap)          state_d = S_DRAIN;
                else if (hdr_push) state_d = S_BURST;
            end
            S_BURST: begin
                if (swap) begin
                    state_d = S_DRAIN;
                end else if (cache_rd && (issue_q == CNT_W'(FRAME_WORDS - 1))) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // occ_d lets END follow the last pop by exactly one cycle.
                if ((inflight == '0) && (occ_d == 3'd0)) state_d = S_END;
            end
            S_END: begin
                // An aborted frame or a swap landing on END restarts at the header.
                if (swap || abort_q) state_d = S_HDR0;
                else                 state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: cache read strobe, header pushes and the end-of-packet pulse.
    always_comb begin
        cache_rd   = 1'b0;
        hdr_push   = 1'b0;
        hdr_data   = USB_DATA_NBIT'(HDR_WORD);
        usb_pktend = 1'b0;
        case (state_q)
            S_HDR0: begin
                hdr_push = !swap && (occ_q != 3'd4);
                hdr_data = USB_DATA_NBIT'(HDR_WORD);
            end
            S_HDR1: begin
                hdr_push = !swap && (occ_q != 3'd4);
                hdr_data = USB_DATA_NBIT'(fcnt_q);
            end
            S_BURST: begin
                cache_rd = !swap && credit_ok && (issue_q < CNT_W'(FRAME_WORDS));
            end
            S_END: begin
                usb_pktend = 1'b1;
            end
            default: begin
                cache_rd = 1'b0;
            end
        endcase
    end

    // Frame bookkeeping: issue counter, abort marker, overrun flag, frame counter.
    always_comb begin
        issue_d = issue_q;
        abort_d = abort_q;
        ovr_d   = ovr_q;
        fcnt_d  = fcnt_q;
        if (state_q == S_HDR0) begin
            issue_d = '0;
        end else if (cache_rd) begin
            issue_d = issue_q + CNT_W'(1);
        end
        if (frame_swap) begin
            abort_d = 1'b1;
            ovr_d   = 1'b1;
        end else if (state_q == S_END) begin
            abort_d = 1'b0;
        end
        if (flush) begin
            ovr_d = 1'b0;
        end
        if ((state_q == S_END) && !abort_q) begin
            fcnt_d = fcnt_q + 16'd1;
        end
    end

    // Skid buffer pointer/occupancy update; a push and pop together keep occupancy.
    always_comb begin
        if (flush) begin
            wptr_d = 2'd0;
            rptr_d = 2'd0;
            occ_d  = 3'd0;
        end else begin
            wptr_d = wptr_q + 2'(push);
            rptr_d = rptr_q + 2'(pop);
            occ_d  = occ_q + 3'(push) - 3'(pop);
        end
    end

    // Control registers: swap detector, read pipeline, counters and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_q      <= 1'b0;
            rd_pipe_q <= '0;
            issue_q   <= '0;
            abort_q   <= 1'b0;
            ovr_q     <= 1'b0;
            fcnt_q    <= 16'd0;
            wptr_q    <= 2'd0;
            rptr_q    <= 2'd0;
            occ_q     <= 3'd0;
        end else begin
            sw_q         <= switch;
            rd_pipe_q[0] <= cache_rd;
            for (int i = 1; i < RD_LAT; i++) begin
                rd_pipe_q[i] <= rd_pipe_q[i-1];
            end
            issue_q <= issue_d;
            abort_q <= abort_d;
            ovr_q   <= ovr_d;
            fcnt_q  <= fcnt_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            occ_q   <= occ_d;
        end
    end

    // Skid buffer storage; cleared on reset so usb_data reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                skid_q[i] <= '0;
            end
        end else if (push && !flush) begin
            skid_q[wptr_q] <= push_data;
        end
    end

endmodule

// File: tb/tb_ad_rd_sched.sv
// Bench for ad_rd_sched: cache model, frame-level scoreboard and directed/random stimulus.
module tb_ad_rd_sched;

    localparam int          FW  = 12;
    localparam int          LAT = 2;
    localparam logic [15:0] HDR = 16'hEB90;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        sw;
    logic        cache_rd;
    logic [15:0] cache_rdata;
    logic        usb_full;
    logic        usb_wr;
    logic [15:0] usb_data;
    logic        usb_pktend;
    logic        overrun;
    logic [15:0] frame_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int bp_mode = 0;
    logic [15:0] acc_q [$];

    // scoreboard state
    logic        m_sw, m_act, m_abt, m_ovr, m_stall;
    logic [15:0] m_cnt, m_stall_d;
    int          m_k, m_rds, m_dacc, m_last, cyc;

    // cache model
    logic [15:0] cpipe [LAT];
    logic [11:0] cptr;
    logic        csw;

    logic [15:0] exp_clean [14] = '{16'hEB90, 16'h0000, 16'hD000, 16'hD001, 16'hD002,
                                     16'hD003, 16'hD004, 16'hD005, 16'hD006, 16'hD007,
                                     16'hD008, 16'hD009, 16'hD00A, 16'hD00B};

    always #5 clk = ~clk;

    ad_rd_sched #(
        .FRAME_WORDS  (FW),
        .RD_LAT       (LAT),
        .HDR_WORD     (HDR),
        .USB_DATA_NBIT(16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .switch     (sw),
        .cache_rd   (cache_rd),
        .cache_rdata(cache_rdata),
        .usb_full   (usb_full),
        .usb_wr     (usb_wr),
        .usb_data   (usb_data),
        .usb_pktend (usb_pktend),
        .overrun    (overrun),
        .frame_cnt  (frame_cnt)
    );

    // Cache: read pointer resets on a half swap, data = D000 + address, RD_LAT cycles late.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csw  <= 1'b0;
            cptr <= '0;
            for (int i = 0; i < LAT; i++) cpipe[i] <= 16'hDEAD;
        end else begin
            csw      <= sw;
            cpipe[0] <= cache_rd ? (16'hD000 + {4'h0, cptr}) : 16'hDEAD;
            for (int i = 1; i < LAT; i++) cpipe[i] <= cpipe[i-1];
            if (sw != csw)     cptr <= '0;
            else if (cache_rd) cptr <= cptr + 12'd1;
        end
    end
    assign cache_rdata = cpipe[LAT-1];

    // USB back-pressure driver: 0 = never full, 1 = random 50%, 2 = always full.
    initial begin
        usb_full = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode == 1)      usb_full = 1'($urandom_range(0, 1));
            else if (bp_mode == 2) usb_full = 1'b1;
            else                   usb_full = 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Scoreboard: frame-level rules evaluated once per cycle on the falling edge.
    initial begin
        logic        sw_now, swap, act_old, nf;
        logic [15:0] expw;
        m_sw = 0; m_act = 0; m_abt = 0; m_ovr = 0; m_stall = 0; m_cnt = 0; m_stall_d = 0;
        m_k = 0; m_rds = 0; m_dacc = 0; m_last = 0; cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n !== 1'b1) begin
                m_sw = 0; m_act = 0; m_abt = 0; m_ovr = 0; m_stall = 0; m_cnt = 0;
                m_k = 0; m_rds = 0; m_dacc = 0;
            end else begin
                sw_now  = sw;
                swap    = sw_now ^ m_sw;
                act_old = m_act;
                chk("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
                chk("overrun", 32'(overrun), 32'(m_ovr));
                if (!m_act) chk("wr_while_idle", 32'(usb_wr), 32'd0);
                if (cache_rd) begin
                    chk("rd_allowed", 32'(m_act && !swap && !m_abt && !usb_pktend), 32'd1);
                    m_rds++;
                end
                if (m_stall) begin
                    chk("hold_wr", 32'(usb_wr), 32'd1);
                    chk("hold_data", 32'(usb_data), 32'(m_stall_d));
                end
                if (usb_wr && !usb_full) begin
                    if (m_k == 0)      expw = HDR;
                    else if (m_k == 1) expw = m_cnt;
                    else               expw = 16'hD000 + 16'(m_k - 2);
                    chk("word", 32'(usb_data), 32'(expw));
                    acc_q.push_back(usb_data);
                    if (m_k >= 2) m_dacc++;
                    m_k++;
                    m_last = cyc;
                end
                chk("outstanding_le4", 32'((m_rds - m_dacc) <= 4), 32'd1);
                m_stall   = usb_wr && usb_full;
                m_stall_d = usb_data;
                if (usb_pktend) begin
                    chk("pkt_in_frame", 32'(m_act), 32'd1);
                    chk("pkt_words_vs_reads", 32'(m_dacc), 32'(m_rds));
                    if (!m_abt) begin
                        chk("frame_len", 32'(m_k), 32'(FW + 2));
                        chk("pkt_after_last_pop", 32'(cyc - m_last), 32'd1);
                        m_cnt = m_cnt + 16'd1;
                    end
                    nf    = m_abt || swap;
                    m_act = nf;
                    m_abt = 0; m_k = 0; m_rds = 0; m_dacc = 0;
                end else if (swap) begin
                    if (m_act) begin
                        m_abt = 1;
                        m_ovr = 1;
                    end else if (en) begin
                        m_act = 1;
                        m_k = 0; m_rds = 0; m_dacc = 0;
                    end
                end
                if (!act_old && !en) m_ovr = 0;
                m_sw = sw_now;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic nstep;
        @(negedge clk);
        #1;
    endtask

    task automatic toggle;
        tick;
        sw = ~sw;
    endtask

    task automatic wait_pkt(input int bound);
        logic got;
        got = 1'b0;
        for (int i = 0; i < bound && !got; i++) begin
            nstep;
            got = usb_pktend;
        end
        chk("pktend_within_bound", 32'(got), 32'd1);
    endtask

    task automatic wait_rds(input int n, input int bound);
        int seen;
        seen = 0;
        for (int i = 0; i < bound && seen < n; i++) begin
            nstep;
            if (cache_rd) seen++;
        end
        chk("cache_rd_within_bound", 32'(seen), 32'(n));
    endtask

    task automatic check_frame(input string nm, input logic [15:0] hdr1);
        logic [15:0] e;
        chk({nm, "_len"}, 32'(acc_q.size()), 32'd14);
        for (int i = 0; i < 14 && i < acc_q.size(); i++) begin
            e = (i == 1) ? hdr1 : exp_clean[i];
            chk({nm, "_word"}, 32'(acc_q[i]), 32'(e));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int traffic;
        rst_n = 1'b0;
        en    = 1'b1;
        sw    = 1'b0;
        #3;
        chk("rst_cache_rd", 32'(cache_rd), 32'd0);
        chk("rst_usb_wr", 32'(usb_wr), 32'd0);
        chk("rst_usb_data", 32'(usb_data), 32'd0);
        chk("rst_pktend", 32'(usb_pktend), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        tick; tick;
        rst_n = 1'b1;

        // Idle with en=1 and no toggles: nothing moves.
        traffic = 0;
        for (int i = 0; i < 100; i++) begin
            nstep;
            if (cache_rd || usb_wr || usb_pktend || overrun || (frame_cnt != 0) || (usb_data != 0))
                traffic++;
        end
        chk("idle_quiet", 32'(traffic), 32'd0);

        // Clean frame with exact latency of the first header word and first read.
        acc_q.delete();
        toggle;
        nstep; chk("lat_swap_wr", 32'(usb_wr), 32'd0);
        nstep; chk("lat_hdr0_wr", 32'(usb_wr), 32'd0);
        nstep; chk("lat_n2_wr", 32'(usb_wr), 32'd1);
               chk("lat_n2_data", 32'(usb_data), 32'hEB90);
        nstep; chk("lat_n3_rd", 32'(cache_rd), 32'd1);
        wait_pkt(200);
        check_frame("clean", 16'h0000);
        nstep; chk("clean_cnt", 32'(frame_cnt), 32'd1);

        // Same frame under random back-pressure.
        bp_mode = 1;
        acc_q.delete();
        toggle;
        wait_pkt(800);
        check_frame("bp", 16'h0001);
        bp_mode = 0;
        nstep; chk("bp_cnt", 32'(frame_cnt), 32'd2);

        // Overrun after five burst reads.
        tick; tick;
        acc_q.delete();
        toggle;
        wait_rds(5, 100);
        toggle;
        wait_pkt(100);
        chk("ovr_partial_len", 32'(acc_q.size()), 32'd7);
        chk("ovr_flag", 32'(overrun), 32'd1);
        chk("ovr_cnt_held", 32'(frame_cnt), 32'd2);
        acc_q.delete();
        wait_pkt(200);
        check_frame("ovr_next", 16'h0002);
        nstep; chk("ovr_next_cnt", 32'(frame_cnt), 32'd3);

        // en falls during BURST: the frame completes, then overrun clears in IDLE.
        tick; tick;
        acc_q.delete();
        toggle;
        wait_rds(1, 50);
        tick;
        en = 1'b0;
        wait_pkt(200);
        check_frame("endrop", 16'h0003);
        chk("endrop_ovr_still", 32'(overrun), 32'd1);
        nstep; nstep;
        chk("endrop_ovr_clear", 32'(overrun), 32'd0);
        chk("endrop_cnt", 32'(frame_cnt), 32'd4);
        traffic = 0;
        for (int i = 0; i < 30; i++) begin
            tick;
            if (i % 10 == 3) sw = ~sw;
            nstep;
            if (cache_rd || usb_wr || usb_pktend) traffic++;
        end
        chk("en0_no_traffic", 32'(traffic), 32'd0);

        // Asynchronous reset in the middle of a burst.
        en = 1'b1;
        tick;
        toggle;
        wait_rds(2, 50);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_cache_rd", 32'(cache_rd), 32'd0);
        chk("arst_usb_wr", 32'(usb_wr), 32'd0);
        chk("arst_usb_data", 32'(usb_data), 32'd0);
        chk("arst_pktend", 32'(usb_pktend), 32'd0);
        chk("arst_frame_cnt", 32'(frame_cnt), 32'd0);
        sw = 1'b0;
        tick; tick;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick;
        acc_q.delete();
        toggle;
        wait_pkt(200);
        check_frame("arst", 16'h0000);
        nstep; chk("arst_cnt", 32'(frame_cnt), 32'd1);

        // switch already high when reset releases gives exactly one frame.
        tick;
        rst_n = 1'b0;
        sw    = 1'b1;
        tick; tick;
        acc_q.delete();
        rst_n = 1'b1;
        wait_pkt(200);
        check_frame("sw_high", 16'h0000);

        // Randomised swaps, enable changes and back-pressure under the scoreboard.
        bp_mode = 1;
        for (int i = 0; i < 4000; i++) begin
            tick;
            if ($urandom_range(0, 29) == 0) sw = ~sw;
            if ($urandom_range(0, 299) == 0)              en = ~en;
            else if (!en && $urandom_range(0, 39) == 0)   en = 1'b1;
        end
        bp_mode = 0;
        en = 1'b1;
        for (int i = 0; i < 200; i++) tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
